// File: rtl/bi_pkg.sv
// Shared definitions for the bus-invert receive stage: word width, word type and popcount.
package bi_pkg;

  localparam int unsigned BI_W = 8;

  typedef logic [BI_W-1:0] bi_word_t;

  // Counts set bits across a data word plus its invert line (BI_W+1 bits, max 9).
  function automatic logic [3:0] popcount(input logic [BI_W:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < BI_W + 1; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bi_rx_fifo.sv
// Receive FIFO for bi_rx_stage: storage, wrapping pointers and occupancy level.
module bi_rx_fifo
  import bi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  bi_word_t                   data_i,
  output bi_word_t                   data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  bi_word_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            pop_ok;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == FULL_LVL);
  assign pop_ok  = pop_i & valid_o;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

  // Storage is not reset; the read path is gated by valid_o instead.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push_i, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/bi_rx_stage.sv
// Bus-invert receive stage: decodes incoming words into a FIFO with sticky overflow flag.
// Optional transition statistics are enabled by defining BI_RX_STATS_EN.
module bi_rx_stage
  import bi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bus_valid,
  input  logic [7:0]             bus_data,
  input  logic                   bus_invert,
  output logic [7:0]             dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow_err,
  input  logic                   clr_err
`ifdef BI_RX_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [15:0]            trans_raw,
  output logic [15:0]            trans_enc
`endif
);

  bi_word_t decoded;
  logic     full, pop, push, drop;
  logic     overflow_q, overflow_d;

  assign decoded = bus_invert ? ~bus_data : bus_data;
  assign pop     = dout_valid & dout_ready;
  assign push    = bus_valid & (~full | pop);
  assign drop    = bus_valid & full & ~pop;

  bi_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (decoded),
    .data_o  (dout),
    .valid_o (dout_valid),
    .full_o  (full),
    .level_o (fifo_level)
  );

  // A drop on the same edge as clr_err leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow_err = overflow_q;

`ifdef BI_RX_STATS_EN
  logic [8:0]  prev_enc_q, prev_enc_d;
  bi_word_t    prev_dec_q, prev_dec_d;
  logic [15:0] trans_raw_q, trans_raw_d;
  logic [15:0] trans_enc_q, trans_enc_d;
  logic [16:0] sum_raw, sum_enc;

  assign sum_enc = {1'b0, trans_enc_q} + 17'(popcount({bus_invert, bus_data} ^ prev_enc_q));
  assign sum_raw = {1'b0, trans_raw_q} + 17'(popcount({1'b0, decoded ^ prev_dec_q}));

  always_comb begin
    prev_enc_d  = prev_enc_q;
    prev_dec_d  = prev_dec_q;
    trans_enc_d = trans_enc_q;
    trans_raw_d = trans_raw_q;
    if (bus_valid) begin
      prev_enc_d  = {bus_invert, bus_data};
      prev_dec_d  = decoded;
      trans_enc_d = sum_enc[16] ? '1 : sum_enc[15:0];
      trans_raw_d = sum_raw[16] ? '1 : sum_raw[15:0];
    end
    if (stats_clr) begin
      trans_enc_d = '0;
      trans_raw_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_enc_q  <= '0;
      prev_dec_q  <= '0;
      trans_enc_q <= '0;
      trans_raw_q <= '0;
    end else begin
      prev_enc_q  <= prev_enc_d;
      prev_dec_q  <= prev_dec_d;
      trans_enc_q <= trans_enc_d;
      trans_raw_q <= trans_raw_d;
    end
  end

  assign trans_enc = trans_enc_q;
  assign trans_raw = trans_raw_q;
`endif

endmodule

// File: tb/tb_bi_rx_stage.sv
// Scoreboard bench for bi_rx_stage; stats checks compile in when BI_RX_STATS_EN is defined.
module tb_bi_rx_stage;

  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic       bus_invert;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] fifo_level;
  logic       overflow_err;
  logic       clr_err;
`ifdef BI_RX_STATS_EN
  logic        stats_clr;
  logic [15:0] trans_raw;
  logic [15:0] trans_enc;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          mlevel = 0;
  logic [7:0]  expq[$];

  bi_rx_stage #(
    .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_valid    (bus_valid),
    .bus_data     (bus_data),
    .bus_invert   (bus_invert),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .fifo_level   (fifo_level),
    .overflow_err (overflow_err),
    .clr_err      (clr_err)
`ifdef BI_RX_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .trans_raw    (trans_raw),
    .trans_enc    (trans_enc)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus; expected words enter the scoreboard when the model accepts them.
  task automatic step(input bit v, input logic inv, input logic [7:0] d, input bit rdy, input bit clr);
    bit pop, acc;
    bus_valid  = v;
    bus_invert = inv;
    bus_data   = d;
    dout_ready = rdy;
    clr_err    = clr;
    pop = rdy && (mlevel > 0);
    acc = v && ((mlevel < int'(DEPTH)) || pop);
    if (acc) expq.push_back(inv ? ~d : d);
    mlevel = mlevel + int'(acc) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst && dout_valid && dout_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_pop: got %0h expected no word at %0t", dout, $time);
      end else begin
        chk("sb_pop", {24'h0, dout}, {24'h0, expq.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b0; bus_valid = 1'b0; bus_data = '0; bus_invert = 1'b0;
    dout_ready = 1'b0; clr_err = 1'b0;
`ifdef BI_RX_STATS_EN
    stats_clr = 1'b0;
`endif
    #2;
    chk("rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("rst_dout", {24'h0, dout}, 32'h0);
    chk("rst_level", {29'h0, fifo_level}, 32'h0);
    chk("rst_ovf", {31'h0, overflow_err}, 32'h0);
`ifdef BI_RX_STATS_EN
    chk("rst_trans_enc", {16'h0, trans_enc}, 32'h0);
    chk("rst_trans_raw", {16'h0, trans_raw}, 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;

    // Single inverted word, latency 1
    step(1, 1, 8'hF0, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("single_dout", {24'h0, dout}, 32'h0F);
    chk("single_valid", {31'h0, dout_valid}, 32'h1);
    chk("single_level", {29'h0, fifo_level}, 32'h1);
    step(0, 0, 8'h00, 1, 0);
    chk("empty_dout", {24'h0, dout}, 32'h0);
    chk("empty_valid", {31'h0, dout_valid}, 32'h0);

    // Five writes into a depth-4 FIFO with no reader
    step(1, 0, 8'h11, 0, 0);
    step(1, 0, 8'h22, 0, 0);
    step(1, 0, 8'h33, 0, 0);
    step(1, 0, 8'h44, 0, 0);
    step(1, 0, 8'h55, 0, 0);
    chk("full_level", {29'h0, fifo_level}, 32'h4);
    chk("full_ovf", {31'h0, overflow_err}, 32'h1);
    chk("full_head", {24'h0, dout}, 32'h11);

    // Clear colliding with a drop, then a clean clear
    step(1, 0, 8'h66, 0, 1);
    chk("clr_vs_drop", {31'h0, overflow_err}, 32'h1);
    step(0, 0, 8'h00, 0, 1);
    chk("clr_alone", {31'h0, overflow_err}, 32'h0);

    // Push and pop together while full
    step(1, 1, 8'h88, 1, 0);
    chk("fullpp_level", {29'h0, fifo_level}, 32'h4);
    chk("fullpp_ovf", {31'h0, overflow_err}, 32'h0);
    chk("fullpp_head", {24'h0, dout}, 32'h22);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
    chk("drain_level", {29'h0, fifo_level}, 32'h0);

    // Mixed traffic with gaps and stalls, exercising pointer wrap
    for (int i = 0; i < 10; i++) begin
      step((i != 3) && (i != 7), i[0], 8'h3C + 8'(i * 17), (i % 3) != 0, 0);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0);
    chk("mixed_level", {29'h0, fifo_level}, 32'h0);

    // Asynchronous reset with words queued
    step(1, 0, 8'hA1, 0, 0);
    step(1, 1, 8'hA2, 0, 0);
    step(1, 0, 8'hA3, 0, 0);
    chk("prerst_level", {29'h0, fifo_level}, 32'h3);
    bus_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'h0, dout_valid}, 32'h0);
    chk("arst_level", {29'h0, fifo_level}, 32'h0);
    chk("arst_dout", {24'h0, dout}, 32'h0);
    expq.delete();
    mlevel = 0;
    @(posedge clk); #1;
    rst = 1'b1;

`ifdef BI_RX_STATS_EN
    step(1, 0, 8'h00, 1, 0);
    step(1, 1, 8'h00, 1, 0);
    chk("stats_enc", {16'h0, trans_enc}, 32'h1);
    chk("stats_raw", {16'h0, trans_raw}, 32'h8);
    for (int k = 0; k < 8200; k++) step(1, 0, (k % 2) ? 8'hFF : 8'h00, 1, 0);
    chk("sat_enc", {16'h0, trans_enc}, 32'hFFFF);
    chk("sat_raw", {16'h0, trans_raw}, 32'hFFFF);
    stats_clr = 1'b1;
    step(1, 1, 8'h5A, 1, 0);
    stats_clr = 1'b0;
    chk("sclr_enc", {16'h0, trans_enc}, 32'h0);
    chk("sclr_raw", {16'h0, trans_raw}, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
`endif

    chk("sb_empty", expq.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bi_rx_stage.md
BI_RX_STAGE -- requirements
Module: bi_rx_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, receive FIFO depth in words, power of two, range 2..16.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port bus_valid, input, 1, encoded bus word present this cycle; there is no backpressure to the source.
REQ-005 SHALL have port bus_data, input, 8, bus-invert-encoded data lines.
REQ-006 SHALL have port bus_invert, input, 1, invert line accompanying bus_data.
REQ-007 SHALL have port dout, output, 8, decoded word at FIFO head.
REQ-008 SHALL have port dout_valid, output, 1, dout holds a valid word.
REQ-009 SHALL have port dout_ready, input, 1, consumer accepts dout.
REQ-010 SHALL have port fifo_level, output, $clog2(DEPTH)+1, current occupancy.
REQ-011 SHALL have port overflow_err, output, 1, sticky word-dropped flag.
REQ-012 SHALL have port clr_err, input, 1, clears overflow_err.
REQ-013 SHALL have ports stats_clr (input, 1), trans_raw (output, 16) and trans_enc (output, 16), present only when the REQ-030 macro is defined.

Function
REQ-014 SHALL compute decoded = bus_invert ? ~bus_data : bus_data.
REQ-015 SHALL push decoded into the FIFO on every clk edge where bus_valid=1 and a push is permitted.
REQ-016 SHALL have latency 1: a word pushed into an empty FIFO at edge N appears on dout with dout_valid=1 after edge N.
REQ-017 SHALL pop on an edge where dout_valid=1 and dout_ready=1; dout SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-018 SHALL drive dout=8'h00 and dout_valid=0 when the FIFO is empty.
REQ-019 SHALL permit a push when full if a pop occurs on the same edge; fifo_level is then unchanged.
REQ-020 SHALL drop the word when bus_valid=1, the FIFO is full and no pop occurs, and SHALL set overflow_err on that edge.
REQ-021 SHALL keep overflow_err set until an edge with clr_err=1; if clr_err and a new drop occur on the same edge, set SHALL win.
REQ-022 SHALL update fifo_level by +1, −1 or 0 on each edge; it never exceeds DEPTH and never underflows.
REQ-023 SHALL preserve FIFO order and wrap pointers modulo DEPTH.

Reset
REQ-024 SHALL, while rst=0, asynchronously force the FIFO empty with pointers at 0, fifo_level=0, dout_valid=0, dout=8'h00 and overflow_err=0.
REQ-025 SHALL, while rst=0, also force trans_raw=0, trans_enc=0 and the prev registers to 0 (macro builds).
REQ-026 SHALL, on reset assertion mid-operation, discard all queued words and SHALL NOT produce a partial pop.

Configuration
REQ-027 SHALL, with BI_RX_STATS_EN defined, keep registers prev_enc (9 bits, {invert,data}) and prev_dec (8 bits).
REQ-028 SHALL, on every bus_valid edge (including dropped words), add popcount({bus_invert,bus_data}^prev_enc) to trans_enc, add popcount(decoded^prev_dec) to trans_raw, then update both prev registers.
REQ-029 SHALL saturate both counters at 16'hFFFF; stats_clr=1 zeroes both counters (clear wins over an add on the same edge) while the prev registers still update.
REQ-030 SHALL, without BI_RX_STATS_EN, omit the counters, the prev registers and their ports, with all other behaviour identical.

Structure
REQ-031 SHALL place BI_W=8, the bi_word_t typedef and the popcount function in shared package bi_pkg.
REQ-032 SHALL implement the FIFO storage, pointers and level as sub-module bi_rx_fifo; decode and stats logic SHALL live in bi_rx_stage.

Verification
REQ-033 SHALL cover: bus_data=8'hF0, bus_invert=1, single valid -> next cycle dout=8'h0F, dout_valid=1, fifo_level=1.
REQ-034 SHALL cover: DEPTH=4, 5 consecutive valids with dout_ready=0 -> fifo_level=4, overflow_err=1, dout equals the first word; words 1-4 then drain in order.
REQ-035 SHALL cover: full FIFO, bus_valid=1 and dout_ready=1 on the same edge -> fifo_level stays 4, no overflow, new word ends up last.
REQ-036 SHALL cover: clr_err=1 together with a drop -> overflow_err stays 1; clr_err alone on the next edge -> 0.
REQ-037 SHALL cover (stats build): words {0,8'h00} then {1,8'h00} -> trans_enc=1, trans_raw=8; counter preset near 16'hFFFF then more toggles -> holds 16'hFFFF.
REQ-038 SHALL cover: rst=0 asserted with 3 words queued -> dout_valid=0, fifo_level=0 immediately, without waiting for a clk edge.
